// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, cfg bit positions and frame
// length decoding used by the TX and RX paths of uart_fifo_core.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  localparam int CFG_W       = 5;
  localparam int CFG_LEN_LSB = 0;
  localparam int CFG_LEN_MSB = 1;
  localparam int CFG_PAR_EN  = 2;
  localparam int CFG_PAR_ODD = 3;
  localparam int CFG_STOP2   = 4;

  // Code 0..3 selects 5..8 data bits; never more than the core can hold.
  function automatic logic [3:0] decode_len(input logic [1:0] len_code,
                                            input int unsigned data_max);
    int unsigned n;
    n = 32'd5 + 32'(len_code);
    if (n > data_max) n = data_max;
    return 4'(n);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO for received words; head word is presented combinationally
// and reads as zero while empty. A push into a full FIFO is dropped unless a pop
// frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_full, w_empty, w_pop, w_push;

  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_pop      = i_pop && !w_empty;
  assign w_push     = i_push && (!w_full || w_pop);
  assign o_overflow = i_push && w_full && !w_pop;
  assign o_valid    = !w_empty;
  assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_fifo_core.sv
// UART transmitter and oversampling receiver sharing one baud tick generator;
// received words (with parity/framing flags) are queued in uart_rx_fifo.
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int DATA_MAX  = 8,
  parameter int OVS       = 16,
  parameter int DIV_W     = 16,
  parameter int RXF_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DIV_W-1:0]    baud_div,
  input  logic [CFG_W-1:0]    cfg,
  input  logic [DATA_MAX-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                tx_sn,
  output logic                tx_busy,
  input  logic                rx_sn,
  output logic [DATA_MAX-1:0] rx_data,
  output logic                rx_perr,
  output logic                rx_ferr,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                rx_overrun,
  input  logic                err_clr
);

  localparam int TCW = $clog2(OVS);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(OVS - 1);
  localparam logic [TCW-1:0] TICK_MID  = TCW'(OVS / 2 - 1);

  logic [DIV_W-1:0] r_baud_cnt, r_baud_div;
  logic             w_tick;

  // The active divisor is reloaded only at wrap so a change never shortens a tick.
  assign w_tick = (r_baud_cnt == r_baud_div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_baud_cnt <= '0;
      r_baud_div <= '0;
    end else if (w_tick) begin
      r_baud_cnt <= '0;
      r_baud_div <= baud_div;
    end else begin
      r_baud_cnt <= r_baud_cnt + 1'b1;
    end
  end

  tx_state_t           r_tx_state;
  logic [TCW-1:0]      r_tx_tick;
  logic [3:0]          r_tx_bit, r_tx_len;
  logic [DATA_MAX-1:0] r_tx_shift;
  logic                r_tx_par_en, r_tx_par, r_tx_stop2, r_tx_stop_cnt, r_tx_sn;
  logic [3:0]          w_tx_len_in;
  logic [DATA_MAX-1:0] w_tx_mask, w_rx_bit_sel;
  logic                w_tx_par_in, w_tx_bit_end;

  rx_state_t           r_rx_state;
  logic                r_rx_s1, r_rx_s2;
  logic [TCW-1:0]      r_rx_tick;
  logic [3:0]          r_rx_bit, r_rx_len;
  logic [DATA_MAX-1:0] r_rx_data;
  logic                r_rx_par_en, r_rx_par_odd, r_rx_perr, r_rx_overrun;
  logic                w_rx_sample, w_rx_mid, w_push, w_overflow;
  logic [DATA_MAX+1:0] w_push_word, w_head;

  assign w_tx_len_in = decode_len(cfg[CFG_LEN_MSB:CFG_LEN_LSB], DATA_MAX);

  for (genvar gi = 0; gi < DATA_MAX; gi++) begin : g_bits
    assign w_tx_mask[gi]    = (4'(gi) < w_tx_len_in);
    assign w_rx_bit_sel[gi] = (4'(gi) == r_rx_bit);
  end

  assign w_tx_par_in  = (^(tx_data & w_tx_mask)) ^ cfg[CFG_PAR_ODD];
  assign w_tx_bit_end = w_tick && (r_tx_tick == TICK_LAST);
  assign tx_ready     = (r_tx_state == TX_IDLE);
  assign tx_busy      = (r_tx_state != TX_IDLE);
  assign tx_sn        = r_tx_sn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state    <= TX_IDLE;
      r_tx_tick     <= '0;
      r_tx_bit      <= '0;
      r_tx_len      <= '0;
      r_tx_shift    <= '0;
      r_tx_par_en   <= 1'b0;
      r_tx_par      <= 1'b0;
      r_tx_stop2    <= 1'b0;
      r_tx_stop_cnt <= 1'b0;
      r_tx_sn       <= 1'b1;
    end else begin
      if (r_tx_state != TX_IDLE && w_tick)
        r_tx_tick <= w_tx_bit_end ? '0 : r_tx_tick + 1'b1;
      case (r_tx_state)
        TX_IDLE: begin
          r_tx_sn <= 1'b1;
          if (tx_valid) begin
            r_tx_state  <= TX_START;
            r_tx_sn     <= 1'b0;
            r_tx_tick   <= '0;
            r_tx_shift  <= tx_data & w_tx_mask;
            r_tx_len    <= w_tx_len_in;
            r_tx_par    <= w_tx_par_in;
            r_tx_par_en <= cfg[CFG_PAR_EN];
            r_tx_stop2  <= cfg[CFG_STOP2];
          end
        end
        TX_START: if (w_tx_bit_end) begin
          r_tx_state <= TX_DATA;
          r_tx_sn    <= r_tx_shift[0];
          r_tx_bit   <= '0;
        end
        TX_DATA: if (w_tx_bit_end) begin
          if (r_tx_bit == r_tx_len - 4'd1) begin
            r_tx_state    <= r_tx_par_en ? TX_PARITY : TX_STOP;
            r_tx_sn       <= r_tx_par_en ? r_tx_par : 1'b1;
            r_tx_stop_cnt <= 1'b0;
          end else begin
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_sn    <= r_tx_shift[1];
            r_tx_bit   <= r_tx_bit + 4'd1;
          end
        end
        TX_PARITY: if (w_tx_bit_end) begin
          r_tx_state    <= TX_STOP;
          r_tx_sn       <= 1'b1;
          r_tx_stop_cnt <= 1'b0;
        end
        TX_STOP: if (w_tx_bit_end) begin
          if (r_tx_stop2 && !r_tx_stop_cnt) r_tx_stop_cnt <= 1'b1;
          else                              r_tx_state    <= TX_IDLE;
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign w_rx_sample = w_tick && (r_rx_tick == TICK_LAST);
  assign w_rx_mid    = w_tick && (r_rx_tick == TICK_MID);
  assign w_push      = (r_rx_state == RX_STOP) && w_rx_sample;
  assign w_push_word = {~r_rx_s2, r_rx_perr, r_rx_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1      <= 1'b1;
      r_rx_s2      <= 1'b1;
      r_rx_state   <= RX_IDLE;
      r_rx_tick    <= '0;
      r_rx_bit     <= '0;
      r_rx_len     <= '0;
      r_rx_data    <= '0;
      r_rx_par_en  <= 1'b0;
      r_rx_par_odd <= 1'b0;
      r_rx_perr    <= 1'b0;
    end else begin
      r_rx_s1 <= rx_sn;
      r_rx_s2 <= r_rx_s1;
      if (r_rx_state != RX_IDLE && w_tick)
        r_rx_tick <= w_rx_sample ? '0 : r_rx_tick + 1'b1;
      case (r_rx_state)
        RX_IDLE: if (!r_rx_s2) begin
          r_rx_state   <= RX_START;
          r_rx_tick    <= '0;
          r_rx_bit     <= '0;
          r_rx_data    <= '0;
          r_rx_perr    <= 1'b0;
          r_rx_len     <= decode_len(cfg[CFG_LEN_MSB:CFG_LEN_LSB], DATA_MAX);
          r_rx_par_en  <= cfg[CFG_PAR_EN];
          r_rx_par_odd <= cfg[CFG_PAR_ODD];
        end
        // Half-bit check rejects glitches and aligns later samples to bit centres.
        RX_START: if (w_rx_mid) begin
          r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          r_rx_tick  <= '0;
        end
        RX_DATA: if (w_rx_sample) begin
          r_rx_data <= r_rx_data | (w_rx_bit_sel & {DATA_MAX{r_rx_s2}});
          if (r_rx_bit == r_rx_len - 4'd1)
            r_rx_state <= r_rx_par_en ? RX_PARITY : RX_STOP;
          else
            r_rx_bit <= r_rx_bit + 4'd1;
        end
        RX_PARITY: if (w_rx_sample) begin
          r_rx_perr  <= (r_rx_s2 != ((^r_rx_data) ^ r_rx_par_odd));
          r_rx_state <= RX_STOP;
        end
        RX_STOP: if (w_rx_sample) r_rx_state <= RX_IDLE;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_rx_overrun <= 1'b0;
    else if (w_overflow) r_rx_overrun <= 1'b1;
    else if (err_clr)    r_rx_overrun <= 1'b0;
  end

  uart_rx_fifo #(
    .WIDTH (DATA_MAX + 2),
    .DEPTH (RXF_DEPTH)
  ) u_rx_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_data     (w_push_word),
    .i_pop      (rx_ready),
    .o_data     (w_head),
    .o_valid    (rx_valid),
    .o_overflow (w_overflow)
  );

  assign rx_ferr    = w_head[DATA_MAX+1];
  assign rx_perr    = w_head[DATA_MAX];
  assign rx_data    = w_head[DATA_MAX-1:0];
  assign rx_overrun = r_rx_overrun;

endmodule

// File: tb/tb_uart_fifo_core.sv
// Scenario bench for uart_fifo_core: expected RX words go into a scoreboard
// queue when frames are sent and are compared as the FIFO presents them.
module tb_uart_fifo_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [4:0]  cfg;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, tx_sn, tx_busy;
  logic        rx_sn;
  logic [7:0]  rx_data;
  logic        rx_perr, rx_ferr, rx_valid, rx_ready, rx_overrun, err_clr;
  logic        loopback, rx_inj;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [9:0]  sb_q[$];

  assign rx_sn = loopback ? tx_sn : rx_inj;

  uart_fifo_core #(
    .DATA_MAX (8), .OVS (16), .DIV_W (16), .RXF_DEPTH (4)
  ) dut (
    .clk (clk), .rst (rst), .baud_div (baud_div), .cfg (cfg),
    .tx_data (tx_data), .tx_valid (tx_valid), .tx_ready (tx_ready),
    .tx_sn (tx_sn), .tx_busy (tx_busy), .rx_sn (rx_sn),
    .rx_data (rx_data), .rx_perr (rx_perr), .rx_ferr (rx_ferr),
    .rx_valid (rx_valid), .rx_ready (rx_ready),
    .rx_overrun (rx_overrun), .err_clr (err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_tx(input logic [7:0] d);
    tx_data = d; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic inject_frame(input logic [15:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      rx_inj = bits[i];
      repeat (16) @(posedge clk);
      #1;
    end
    rx_inj = 1'b1;
  endtask

  task automatic wait_rx_valid(input int budget, output int waited);
    waited = 0;
    @(negedge clk);
    while (!rx_valid && waited < budget) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic pop_word();
    @(posedge clk); #1 rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
  endtask

  task automatic wait_tx_idle(input int budget, output int waited);
    waited = 0;
    @(negedge clk);
    while (!tx_ready && waited < budget) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    outs = {tx_sn, tx_busy, tx_ready, rx_valid, rx_perr, rx_ferr, rx_overrun, 1'b0};
    n_checks++;
    if (outs !== 8'b1010_0000 || rx_data !== 8'h00)
      $display("FAIL reset_hold: outputs %b data %h, required 10100000 data 00", outs, rx_data);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    outs = {tx_sn, tx_busy, tx_ready, rx_valid, rx_perr, rx_ferr, rx_overrun, 1'b0};
    n_checks++;
    if (outs !== 8'b1010_0000 || rx_data !== 8'h00)
      $display("FAIL reset_release: outputs %b data %h, required 10100000 data 00", outs, rx_data);
    else n_pass++;
    $display("reset: checked outputs during and after reset");
  endtask

  task automatic test_tx_frame();
    logic [9:0] frame;
    loopback = 1'b0; rx_inj = 1'b1; cfg = 5'b00011;
    frame = {1'b1, 8'hA5, 1'b0};
    @(posedge clk); #1;
    send_tx(8'hA5);
    for (int k = 0; k < 160; k++) begin
      @(negedge clk);
      n_checks++;
      if (tx_sn !== frame[k/16])
        $display("FAIL tx_8n1_bit cycle %0d: tx_sn %b, required %b", k, tx_sn, frame[k/16]);
      else n_pass++;
      if (k == 159) begin
        n_checks++;
        if (tx_ready !== 1'b0 || tx_busy !== 1'b1)
          $display("FAIL tx_8n1_busy: ready %b busy %b, required 0 1", tx_ready, tx_busy);
        else n_pass++;
      end
    end
    @(negedge clk);
    n_checks++;
    if (tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_sn !== 1'b1)
      $display("FAIL tx_8n1_done: ready %b busy %b sn %b, required 1 0 1", tx_ready, tx_busy, tx_sn);
    else n_pass++;
    $display("tx 8N1 0xA5: waveform checked over 160 cycles");
  endtask

  task automatic test_loopback_7e2();
    int lat, w;
    logic [9:0] exp;
    loopback = 1'b1; cfg = 5'b10110;
    sb_q.push_back({1'b0, 1'b0, 8'h55});
    @(posedge clk); #1;
    send_tx(8'h55);
    wait_rx_valid(400, lat);
    n_checks++;
    if (lat !== 155)
      $display("FAIL loop_7e2_latency: rx_valid after %0d cycles, required 155", lat);
    else n_pass++;
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 10'h3FF;
    n_checks++;
    if ({rx_ferr, rx_perr, rx_data} !== exp)
      $display("FAIL loop_7e2_word: got %h, required %h", {rx_ferr, rx_perr, rx_data}, exp);
    else n_pass++;
    wait_tx_idle(400, w);
    n_checks++;
    if (w !== 20)
      $display("FAIL loop_7e2_stop2: tx idle %0d cycles after rx_valid, required 20", w);
    else n_pass++;
    pop_word();
    @(negedge clk);
    n_checks++;
    if (rx_valid !== 1'b0 || rx_overrun !== 1'b0)
      $display("FAIL loop_7e2_drain: valid %b overrun %b, required 0 0", rx_valid, rx_overrun);
    else n_pass++;
    $display("loopback 7E2 0x55: latency %0d word %h", lat, exp);
  endtask

  task automatic test_errors();
    int w;
    logic [9:0] exp;
    loopback = 1'b0; rx_inj = 1'b1; cfg = 5'b01111;
    sb_q.push_back({1'b1, 1'b1, 8'h3C});
    @(posedge clk); #1;
    inject_frame({5'b0, 1'b0, 1'b0, 8'h3C, 1'b0}, 11);
    wait_rx_valid(100, w);
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 10'h000;
    n_checks++;
    if (rx_valid !== 1'b1 || {rx_ferr, rx_perr, rx_data} !== exp)
      $display("FAIL err_8o1_word: valid %b got %h, required 1 %h", rx_valid, {rx_ferr, rx_perr, rx_data}, exp);
    else n_pass++;
    pop_word();
    repeat (60) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (rx_valid !== 1'b0)
      $display("FAIL err_8o1_no_extra: rx_valid %b, required 0", rx_valid);
    else n_pass++;
    $display("8O1 bad parity/stop: word %h", exp);
  endtask

  task automatic test_overrun();
    int w, t_prev, t_now;
    logic [7:0] d;
    logic [9:0] exp;
    loopback = 1'b1; cfg = 5'b00011; rx_ready = 1'b0;
    t_prev = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      d = 8'(8'h11 * (i + 1));
      if (i < 4) sb_q.push_back({2'b00, d});
      tx_data = d; tx_valid = 1'b1;
      wait_tx_idle(400, w);
      @(posedge clk); #1;
      t_now = cyc;
      if (i > 0) begin
        n_checks++;
        if (t_now - t_prev !== 161)
          $display("FAIL b2b_interval frame %0d: %0d cycles, required 161", i, t_now - t_prev);
        else n_pass++;
      end
      t_prev = t_now;
    end
    tx_valid = 1'b0;
    wait_tx_idle(400, w);
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (rx_overrun !== 1'b1 || rx_valid !== 1'b1)
      $display("FAIL overrun_set: overrun %b valid %b, required 1 1", rx_overrun, rx_valid);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : 10'h3FF;
      n_checks++;
      if (rx_valid !== 1'b1 || {rx_ferr, rx_perr, rx_data} !== exp)
        $display("FAIL overrun_order %0d: valid %b got %h, required 1 %h", i, rx_valid, {rx_ferr, rx_perr, rx_data}, exp);
      else n_pass++;
      pop_word();
    end
    @(negedge clk);
    n_checks++;
    if (rx_valid !== 1'b0 || rx_overrun !== 1'b1)
      $display("FAIL overrun_empty: valid %b overrun %b, required 0 1", rx_valid, rx_overrun);
    else n_pass++;
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rx_overrun !== 1'b0)
      $display("FAIL overrun_clear: overrun %b, required 0", rx_overrun);
    else n_pass++;
    $display("overrun: 5 frames into depth 4, order and sticky flag checked");
  endtask

  task automatic test_glitch();
    int w;
    logic [9:0] exp;
    loopback = 1'b0; rx_inj = 1'b1; cfg = 5'b00011;
    @(posedge clk); #1 rx_inj = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_inj = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (rx_valid !== 1'b0)
      $display("FAIL glitch_no_push: rx_valid %b, required 0", rx_valid);
    else n_pass++;
    sb_q.push_back({2'b00, 8'h96});
    @(posedge clk); #1;
    inject_frame({6'b0, 1'b1, 8'h96, 1'b0}, 10);
    wait_rx_valid(100, w);
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 10'h3FF;
    n_checks++;
    if (rx_valid !== 1'b1 || {rx_ferr, rx_perr, rx_data} !== exp)
      $display("FAIL glitch_recover: valid %b got %h, required 1 %h", rx_valid, {rx_ferr, rx_perr, rx_data}, exp);
    else n_pass++;
    pop_word();
    $display("glitch: 4-tick pulse ignored, next frame %h", exp);
  endtask

  task automatic test_reset_mid_tx();
    loopback = 1'b1; cfg = 5'b00011;
    @(posedge clk); #1;
    send_tx(8'hF0);
    repeat (60) @(posedge clk);
    #1;
    n_checks++;
    if (tx_busy !== 1'b1 || tx_sn !== 1'b0)
      $display("FAIL rst_mid_pre: busy %b sn %b, required 1 0", tx_busy, tx_sn);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (tx_sn !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1)
      $display("FAIL rst_mid_immediate: sn %b busy %b ready %b, required 1 0 1", tx_sn, tx_busy, tx_ready);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    repeat (250) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (rx_valid !== 1'b0 || tx_sn !== 1'b1)
      $display("FAIL rst_mid_no_push: valid %b sn %b, required 0 1", rx_valid, tx_sn);
    else n_pass++;
    $display("reset mid-frame: line idle and no push");
  endtask

  initial begin
    rst = 1'b1; baud_div = 16'd0; cfg = 5'b00011; tx_data = 8'h00;
    tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
    loopback = 1'b0; rx_inj = 1'b1;
    test_reset();
    test_tx_frame();
    test_loopback_7e2();
    test_errors();
    test_overrun();
    test_glitch();
    test_reset_mid_tx();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
